// File: rtl/core_wb_stage_p.sv
// core_wb_stage_p: writeback stage for the Selen core pipeline.
// Formats the writeback value and tracks outstanding load responses.
// Registers the register-file write port and reports the pending rd.
// Optional load timeout is enabled with the CORE_WB_TIMEOUT_EN macro.
module core_wb_stage_p #(
  parameter int XLEN  = 32,
  parameter int RD_W  = 5,
  parameter int TMO_W = 8,
  localparam int AL_W = $clog2(XLEN/8)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wb_valid_in,
  input  logic            wb_mux_alu_mem_in,
  input  logic            wb_we_reg_file_in,
  input  logic [2:0]      wb_sx_op_in,
  input  logic [RD_W-1:0] wb_rd_in,
  input  logic [AL_W-1:0] wb_addr_lo_in,
  input  logic [XLEN-1:0] wb_alu_result_in,
  input  logic [XLEN-1:0] wb_sx_imm_in,
  input  logic [XLEN-1:0] wb_pc_4_in,
  input  logic [XLEN-1:0] wb_mem_data_in,
  input  logic            wb_ack_from_lid_in,
  output logic            wb_we_reg_file_out,
  output logic [RD_W-1:0] wb_rd_out,
  output logic [XLEN-1:0] wb_data_out,
  output logic            wb_stall_out,
  output logic [RD_W-1:0] wb2haz_rd_out,
  output logic            wb2haz_valid_out,
  output logic            wb_tmo_err_out
);

  // Elaboration-time sanity checks on the parameter set.
  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("core_wb_stage_p: XLEN must be 32 or 64");
  end
  if (TMO_W < 2) begin : g_bad_tmo
    $error("core_wb_stage_p: TMO_W must be at least 2");
  end

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t          state, state_n;
  logic            is_load;
  logic            rd_nz;
  logic            accept;
  logic            tmo_hit;
  logic [XLEN-1:0] lane;
  logic [XLEN-1:0] fmt;

  assign is_load = wb_valid_in & ~wb_mux_alu_mem_in;
  assign rd_nz   = |wb_rd_in;
  assign accept  = wb_valid_in & (wb_mux_alu_mem_in | wb_ack_from_lid_in);

`ifdef CORE_WB_TIMEOUT_EN
  // Last count value before the timeout fires; the cycle that would bring
  // the count to all-ones drops the load instead.
  localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

  logic [TMO_W-1:0] tmo_cnt;

  // Count WAIT cycles without a response; held at zero while idle so every
  // entry to WAIT starts from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (state == ST_IDLE) begin
      tmo_cnt <= '0;
    end else if (!wb_ack_from_lid_in) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  assign tmo_hit = (state == ST_WAIT) & ~wb_ack_from_lid_in & (tmo_cnt == TMO_LAST);
`else
  assign tmo_hit = 1'b0;
`endif

  assign wb_tmo_err_out   = tmo_hit;
  assign wb_stall_out     = is_load & ~wb_ack_from_lid_in & ~tmo_hit & ~rst;
  assign wb2haz_rd_out    = wb_rd_in;
  assign wb2haz_valid_out = wb_valid_in & wb_we_reg_file_in & rd_nz;

  // Pick the source lane: loads are shifted down to their byte offset with
  // zero fill at the top, ALU results are used unshifted.
  always_comb begin
    lane = wb_alu_result_in;
    if (!wb_mux_alu_mem_in) begin
      lane = wb_mem_data_in >> {wb_addr_lo_in, 3'b000};
    end
  end

  // Apply the requested result format to the selected lane.
  always_comb begin
    fmt = lane;
    case (wb_sx_op_in)
      3'd0:    fmt = lane;
      3'd1:    fmt = XLEN'(lane[7:0]);
      3'd2:    fmt = XLEN'(signed'(lane[7:0]));
      3'd3:    fmt = XLEN'(signed'(lane[15:0]));
      3'd4:    fmt = XLEN'(lane[15:0]);
      3'd5:    fmt = wb_sx_imm_in;
      3'd6:    fmt = wb_pc_4_in;
      default: fmt = XLEN'(signed'(lane[31:0]));
    endcase
  end

  // Load-response tracking state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state: a load without its response parks in WAIT until the
  // response arrives or the timeout drops it.
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (is_load && !wb_ack_from_lid_in) state_n = ST_WAIT;
      ST_WAIT: if ((is_load && wb_ack_from_lid_in) || tmo_hit) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // Register-file write port: capture on accept, otherwise only the write
  // enable drops while index and data keep their last values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_we_reg_file_out <= 1'b0;
      wb_rd_out          <= '0;
      wb_data_out        <= '0;
    end else if (accept) begin
      wb_we_reg_file_out <= wb_we_reg_file_in & rd_nz;
      wb_rd_out          <= wb_rd_in;
      wb_data_out        <= fmt;
    end else begin
      wb_we_reg_file_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_core_wb_stage_p.sv
// Directed testbench for core_wb_stage_p (XLEN=32 and XLEN=64 instances).
module tb_core_wb_stage_p;

  logic        clk;
  logic        rst;
  logic        valid, mux, we_in, ack;
  logic [2:0]  sx;
  logic [4:0]  rd;
  logic [1:0]  addr_lo;
  logic [31:0] alu, imm, pc, mem;
  logic        we_o, stall, haz_v, tmo;
  logic [4:0]  rd_o, haz_rd;
  logic [31:0] data_o;

  logic        valid64;
  logic [2:0]  addr64;
  logic [63:0] alu64, imm64, pc64, mem64;
  logic        we_o64, stall64, haz_v64, tmo64;
  logic [4:0]  rd_o64, haz_rd64;
  logic [63:0] data_o64;

  int total = 0;
  int bad   = 0;

  core_wb_stage_p #(.XLEN(32), .RD_W(5), .TMO_W(3)) dut (
    .clk(clk), .rst(rst),
    .wb_valid_in(valid), .wb_mux_alu_mem_in(mux), .wb_we_reg_file_in(we_in),
    .wb_sx_op_in(sx), .wb_rd_in(rd), .wb_addr_lo_in(addr_lo),
    .wb_alu_result_in(alu), .wb_sx_imm_in(imm), .wb_pc_4_in(pc),
    .wb_mem_data_in(mem), .wb_ack_from_lid_in(ack),
    .wb_we_reg_file_out(we_o), .wb_rd_out(rd_o), .wb_data_out(data_o),
    .wb_stall_out(stall), .wb2haz_rd_out(haz_rd), .wb2haz_valid_out(haz_v),
    .wb_tmo_err_out(tmo)
  );

  core_wb_stage_p #(.XLEN(64), .RD_W(5), .TMO_W(3)) dut64 (
    .clk(clk), .rst(rst),
    .wb_valid_in(valid64), .wb_mux_alu_mem_in(mux), .wb_we_reg_file_in(we_in),
    .wb_sx_op_in(sx), .wb_rd_in(rd), .wb_addr_lo_in(addr64),
    .wb_alu_result_in(alu64), .wb_sx_imm_in(imm64), .wb_pc_4_in(pc64),
    .wb_mem_data_in(mem64), .wb_ack_from_lid_in(ack),
    .wb_we_reg_file_out(we_o64), .wb_rd_out(rd_o64), .wb_data_out(data_o64),
    .wb_stall_out(stall64), .wb2haz_rd_out(haz_rd64), .wb2haz_valid_out(haz_v64),
    .wb_tmo_err_out(tmo64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    valid = 0; valid64 = 0; mux = 1; we_in = 0; ack = 0; sx = 0; rd = 0;
    addr_lo = 0; alu = 0; imm = 0; pc = 0; mem = 0;
    addr64 = 0; alu64 = 0; imm64 = 0; pc64 = 0; mem64 = 0;
  endtask

  task automatic drive_alu(input logic [4:0] r, input logic [2:0] s, input logic [31:0] a);
    valid = 1; mux = 1; we_in = 1; rd = r; sx = s; alu = a; ack = 0;
  endtask

  task automatic drive_load(input logic [4:0] r, input logic [2:0] s, input logic [1:0] off,
                            input logic [31:0] m, input logic k);
    valid = 1; mux = 0; we_in = 1; rd = r; sx = s; addr_lo = off; mem = m; ack = k;
  endtask

  task automatic test_reset();
    rst = 1;
    drive_idle();
    #2;
    total++;
    if ({we_o, rd_o, data_o, stall, haz_v, tmo} !== 40'd0) begin
      bad++;
      $display("[TB] FAIL reset_state got=%h want=0", {we_o, rd_o, data_o, stall, haz_v, tmo});
    end
    @(negedge clk);
    rst = 0;
    step();
    total++;
    if ({we_o, rd_o, data_o} !== 38'd0) begin
      bad++;
      $display("[TB] FAIL reset_idle got=%h want=0", {we_o, rd_o, data_o});
    end
  endtask

  task automatic test_alu();
    drive_alu(5'd3, 3'd0, 32'h1234_5678);
    #1;
    total++;
    if ({stall, haz_v, haz_rd} !== {1'b0, 1'b1, 5'd3}) begin
      bad++;
      $display("[TB] FAIL alu_comb got=%b/%b/%0d want=0/1/3", stall, haz_v, haz_rd);
    end
    step();
    drive_idle();
    total++;
    if ({we_o, rd_o, data_o} !== {1'b1, 5'd3, 32'h1234_5678}) begin
      bad++;
      $display("[TB] FAIL alu_write got=%b/%0d/%h want=1/3/12345678", we_o, rd_o, data_o);
    end
    step();
    total++;
    if ({we_o, rd_o, data_o} !== {1'b0, 5'd3, 32'h1234_5678}) begin
      bad++;
      $display("[TB] FAIL alu_hold got=%b/%0d/%h want=0/3/12345678", we_o, rd_o, data_o);
    end
  endtask

  task automatic test_load_align();
    logic [1:0]  offs [5] = '{2'd2, 2'd2, 2'd3, 2'd2, 2'd0};
    logic [2:0]  ops  [5] = '{3'd2, 3'd1, 3'd3, 3'd4, 3'd3};
    logic [31:0] mems [5] = '{32'h0080_0000, 32'h0080_0000, 32'hFF00_0000,
                              32'hABCD_0000, 32'h0000_8001};
    logic [31:0] exps [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_00FF,
                              32'h0000_ABCD, 32'hFFFF_8001};
    for (int i = 0; i < 5; i++) begin
      drive_load(5'd4, ops[i], offs[i], mems[i], 1'b1);
      #1;
      total++;
      if (stall !== 1'b0) begin
        bad++;
        $display("[TB] FAIL load_ack_stall[%0d] got=%b want=0", i, stall);
      end
      step();
      total++;
      if ({we_o, rd_o, data_o} !== {1'b1, 5'd4, exps[i]}) begin
        bad++;
        $display("[TB] FAIL load_align[%0d] got=%b/%0d/%h want=1/4/%h", i, we_o, rd_o, data_o, exps[i]);
      end
    end
    drive_idle();
  endtask

  task automatic test_formats();
    drive_alu(5'd5, 3'd5, 32'h0);
    imm = 32'hDEAD_BEEF;
    step();
    total++;
    if (data_o !== 32'hDEAD_BEEF) begin
      bad++;
      $display("[TB] FAIL fmt_imm got=%h want=deadbeef", data_o);
    end
    drive_alu(5'd6, 3'd6, 32'h0);
    pc = 32'h0000_0104;
    step();
    total++;
    if (data_o !== 32'h0000_0104) begin
      bad++;
      $display("[TB] FAIL fmt_pc got=%h want=00000104", data_o);
    end
    drive_alu(5'd8, 3'd2, 32'h0000_00F0);
    addr_lo = 2'd1;
    step();
    total++;
    if (data_o !== 32'hFFFF_FFF0) begin
      bad++;
      $display("[TB] FAIL fmt_alu_b got=%h want=fffffff0", data_o);
    end
    drive_alu(5'd8, 3'd7, 32'h8000_0001);
    step();
    total++;
    if (data_o !== 32'h8000_0001) begin
      bad++;
      $display("[TB] FAIL fmt_w32 got=%h want=80000001", data_o);
    end
    drive_idle();
    step();
  endtask

  task automatic test_load_wait();
    drive_load(5'd7, 3'd0, 2'd0, 32'hCAFE_F00D, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if ({stall, haz_v, haz_rd} !== {1'b1, 1'b1, 5'd7}) begin
        bad++;
        $display("[TB] FAIL wait_comb[%0d] got=%b/%b/%0d want=1/1/7", i, stall, haz_v, haz_rd);
      end
      step();
      total++;
      if (we_o !== 1'b0) begin
        bad++;
        $display("[TB] FAIL wait_no_write[%0d] got=%b want=0", i, we_o);
      end
    end
    ack = 1;
    #1;
    total++;
    if (stall !== 1'b0) begin
      bad++;
      $display("[TB] FAIL wait_ack_stall got=%b want=0", stall);
    end
    step();
    drive_idle();
    total++;
    if ({we_o, rd_o, data_o} !== {1'b1, 5'd7, 32'hCAFE_F00D}) begin
      bad++;
      $display("[TB] FAIL wait_write got=%b/%0d/%h want=1/7/cafef00d", we_o, rd_o, data_o);
    end
    step();
  endtask

  task automatic test_rd_zero();
    drive_alu(5'd0, 3'd0, 32'h1111_2222);
    #1;
    total++;
    if (haz_v !== 1'b0) begin
      bad++;
      $display("[TB] FAIL rd0_haz got=%b want=0", haz_v);
    end
    step();
    drive_idle();
    total++;
    if (we_o !== 1'b0) begin
      bad++;
      $display("[TB] FAIL rd0_we got=%b want=0", we_o);
    end
    ack = 1;
    step();
    total++;
    if ({we_o, stall} !== 2'b00) begin
      bad++;
      $display("[TB] FAIL stray_ack got=%b want=00", {we_o, stall});
    end
    drive_idle();
  endtask

  task automatic test_back_to_back();
    logic [4:0]  rds [3] = '{5'd10, 5'd11, 5'd12};
    logic [31:0] vals[3] = '{32'hA0A0_0001, 32'hB0B0_0002, 32'hC0C0_0003};
    drive_alu(rds[0], 3'd0, vals[0]);
    for (int i = 0; i < 3; i++) begin
      step();
      if (i < 2) drive_alu(rds[i+1], 3'd0, vals[i+1]);
      else drive_idle();
      total++;
      if ({we_o, rd_o, data_o} !== {1'b1, rds[i], vals[i]}) begin
        bad++;
        $display("[TB] FAIL b2b[%0d] got=%b/%0d/%h want=1/%0d/%h", i, we_o, rd_o, data_o, rds[i], vals[i]);
      end
    end
    step();
  endtask

  task automatic test_reset_in_wait();
    drive_load(5'd9, 3'd0, 2'd0, 32'h0000_0055, 1'b0);
    step();
    #1;
    total++;
    if (stall !== 1'b1) begin
      bad++;
      $display("[TB] FAIL rstwait_pre got=%b want=1", stall);
    end
    rst = 1;
    #1;
    total++;
    if ({stall, we_o} !== 2'b00) begin
      bad++;
      $display("[TB] FAIL rstwait_drop got=%b want=00", {stall, we_o});
    end
    step();
    rst = 0;
    #1;
    ack = 1;
    #1;
    total++;
    if (stall !== 1'b0) begin
      bad++;
      $display("[TB] FAIL rstwait_ack got=%b want=0", stall);
    end
    step();
    drive_idle();
    total++;
    if ({we_o, rd_o, data_o} !== {1'b1, 5'd9, 32'h0000_0055}) begin
      bad++;
      $display("[TB] FAIL rstwait_write got=%b/%0d/%h want=1/9/00000055", we_o, rd_o, data_o);
    end
    step();
  endtask

  task automatic test_w64();
    mux = 1; we_in = 1; rd = 5'd2; sx = 3'd7; ack = 0;
    valid64 = 1; alu64 = 64'h0000_0000_8000_0001;
    step();
    total++;
    if ({we_o64, data_o64} !== {1'b1, 64'hFFFF_FFFF_8000_0001}) begin
      bad++;
      $display("[TB] FAIL w64_alu got=%b/%h want=1/ffffffff80000001", we_o64, data_o64);
    end
    mux = 0; ack = 1; addr64 = 3'd4; mem64 = 64'h8000_0000_0000_0000;
    step();
    total++;
    if (data_o64 !== 64'hFFFF_FFFF_8000_0000) begin
      bad++;
      $display("[TB] FAIL w64_load got=%h want=ffffffff80000000", data_o64);
    end
    sx = 3'd4; addr64 = 3'd7; mem64 = 64'hABCD_0000_0000_0000;
    step();
    total++;
    if (data_o64 !== 64'h0000_0000_0000_00AB) begin
      bad++;
      $display("[TB] FAIL w64_top_half got=%h want=00000000000000ab", data_o64);
    end
    drive_idle();
    step();
  endtask

`ifdef CORE_WB_TIMEOUT_EN
  task automatic test_timeout();
    drive_load(5'd13, 3'd0, 2'd0, 32'h7777_0000, 1'b0);
    for (int i = 0; i < 7; i++) begin
      #1;
      total++;
      if ({stall, tmo} !== 2'b10) begin
        bad++;
        $display("[TB] FAIL tmo_stall[%0d] got=%b want=10", i, {stall, tmo});
      end
      step();
    end
    #1;
    total++;
    if ({stall, tmo} !== 2'b01) begin
      bad++;
      $display("[TB] FAIL tmo_pulse got=%b want=01", {stall, tmo});
    end
    step();
    drive_idle();
    total++;
    if ({we_o, tmo} !== 2'b00) begin
      bad++;
      $display("[TB] FAIL tmo_drop got=%b want=00", {we_o, tmo});
    end
    step();
    drive_load(5'd14, 3'd0, 2'd0, 32'h0000_4444, 1'b0);
    for (int i = 0; i < 7; i++) step();
    ack = 1;
    #1;
    total++;
    if ({stall, tmo} !== 2'b00) begin
      bad++;
      $display("[TB] FAIL tmo_ack_wins got=%b want=00", {stall, tmo});
    end
    step();
    drive_idle();
    total++;
    if ({we_o, rd_o, data_o} !== {1'b1, 5'd14, 32'h0000_4444}) begin
      bad++;
      $display("[TB] FAIL tmo_ack_write got=%b/%0d/%h want=1/14/00004444", we_o, rd_o, data_o);
    end
    step();
  endtask
`else
  task automatic test_timeout();
    drive_load(5'd13, 3'd0, 2'd0, 32'h7777_0000, 1'b0);
    for (int i = 0; i < 10; i++) begin
      #1;
      total++;
      if ({stall, tmo} !== 2'b10) begin
        bad++;
        $display("[TB] FAIL notmo_stall[%0d] got=%b want=10", i, {stall, tmo});
      end
      step();
    end
    ack = 1;
    step();
    drive_idle();
    total++;
    if ({we_o, rd_o, data_o} !== {1'b1, 5'd13, 32'h7777_0000}) begin
      bad++;
      $display("[TB] FAIL notmo_write got=%b/%0d/%h want=1/13/77770000", we_o, rd_o, data_o);
    end
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_alu();
    test_load_align();
    test_formats();
    test_load_wait();
    test_rd_zero();
    test_back_to_back();
    test_reset_in_wait();
    test_w64();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
